mem_arb: RTL and testbench

- Shares the single 64-bit memory bus between the instruction fetch unit (IFU, 64-bit fetch packets) and the load-store unit (LSU, 32-bit accesses).
- Picks one requester per cycle and tracks outstanding requests in order.
- Routes each in-order response back to its owner and steers LSU word lanes.
- Drops responses belonging to IFU fetches that a taken jump has flushed.

---
 rtl/srv_defs.sv | 15 +
 rtl/mem_tag_fifo.sv | 53 +++++
 rtl/mem_arb.sv | 113 +++++++++++
 tb/tb_mem_arb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srv_defs.sv
// Shared type definitions for the memory-side service blocks.
package srv_defs;

    typedef enum logic {
        MEM_OWN_IFU,
        MEM_OWN_LSU
    } mem_owner_t;

    typedef struct packed {
        mem_owner_t owner;
        logic       lane;
        logic       drop;
    } mem_tag_t;

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order tag FIFO tracking outstanding bus requests; flush_ifu marks all IFU entries as dropped.
module mem_tag_fifo
    import srv_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mem_tag_t push_tag,
    input  logic     pop,
    input  logic     flush_ifu,
    output logic     full,
    output logic     empty,
    output mem_tag_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    mem_tag_t        entries [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = entries[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // The pushed tag already carries its own drop bit, so it overrides the flush sweep.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_ifu && entries[i].owner == MEM_OWN_IFU) entries[i].drop <= 1'b1;
        end
        if (do_push) entries[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates the 64-bit memory bus between IFU fetches and LSU word accesses,
// routing in-order responses back to their owner.
module mem_arb
    import srv_defs::*;
#(
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_req_ready,
    input  logic        ifu_flush,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    input  logic        lsu_req_we,
    input  logic [3:0]  lsu_req_be,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    output logic        lsu_req_ready,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_resp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [7:0]  mem_req_be,
    output logic [31:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    mem_tag_t      head;
    mem_tag_t      push_tag;
    logic          can_issue;
    logic          ifu_win;
    logic          lsu_win;
    logic          push;
    logic          pop;
    logic          ifu_hs;

    assign can_issue = !fifo_full || (mem_resp_valid && !fifo_empty);
    assign ifu_win   = ifu_req_valid && (!lsu_req_valid || starve_cnt == CW'(STARVE_LIM));
    assign lsu_win   = lsu_req_valid && !ifu_win;

    assign mem_req_valid = !rst && (ifu_req_valid || lsu_req_valid) && can_issue;
    assign ifu_req_ready = !rst && ifu_win && mem_req_ready && can_issue;
    assign lsu_req_ready = !rst && lsu_win && mem_req_ready && can_issue;
    assign ifu_hs        = ifu_req_ready;
    assign push          = mem_req_valid && mem_req_ready;
    assign pop           = !rst && mem_resp_valid && !fifo_empty;

    always_comb begin
        mem_req_wdata = {lsu_req_wdata, lsu_req_wdata};
        if (ifu_win) begin
            mem_req_addr = {ifu_req_addr[31:3], 3'b000};
            mem_req_we   = 1'b0;
            mem_req_be   = 8'hFF;
        end else begin
            mem_req_addr = {lsu_req_addr[31:3], 3'b000};
            mem_req_we   = lsu_req_we;
            mem_req_be   = lsu_req_addr[2] ? {lsu_req_be, 4'h0} : {4'h0, lsu_req_be};
        end
    end

    always_comb begin
        push_tag       = '0;
        push_tag.owner = ifu_win ? MEM_OWN_IFU : MEM_OWN_LSU;
        push_tag.lane  = ifu_win ? 1'b0 : lsu_req_addr[2];
        push_tag.drop  = ifu_win && ifu_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (ifu_hs) begin
            starve_cnt <= '0;
        end else if (ifu_req_valid && starve_cnt != CW'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    mem_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_tag  (push_tag),
        .pop       (pop),
        .flush_ifu (ifu_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // A flush in the pop cycle still kills the head fetch.
    assign lsu_resp_valid = pop && head.owner == MEM_OWN_LSU;
    assign lsu_resp_rdata = head.lane ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
    assign ifu_resp_valid = pop && head.owner == MEM_OWN_IFU && !head.drop && !ifu_flush;
    assign ifu_resp_data  = mem_resp_rdata;

    resp_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(mem_resp_valid && fifo_empty));

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: arbitration, lane steering, backpressure, flush and reset.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_flush;
    logic        ifu_resp_valid;
    logic [63:0] ifu_resp_data;
    logic        lsu_req_valid;
    logic        lsu_req_we;
    logic [3:0]  lsu_req_be;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [7:0]  mem_req_be;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arb #(
        .MAX_OUTST  (4),
        .STARVE_LIM (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_flush      (ifu_flush),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_we     (lsu_req_we),
        .lsu_req_be     (lsu_req_be),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_be     (mem_req_be),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        ifu_flush      = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_req_we     = 1'b0;
        lsu_req_be     = '0;
        lsu_req_addr   = '0;
        lsu_req_wdata  = '0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic ifu_fetch(input logic [31:0] addr, input logic exp_ready);
        idle();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = addr;
        settle();
        check("ifu_fetch_ready", ifu_req_ready, exp_ready);
        tick();
    endtask

    task automatic resp(input logic [63:0] data, input logic exp_ifu, input logic exp_lsu);
        idle();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = data;
        settle();
        check("resp_ifu_valid", ifu_resp_valid, exp_ifu);
        check("resp_lsu_valid", lsu_resp_valid, exp_lsu);
        if (exp_ifu) check("resp_ifu_data", ifu_resp_data, data);
        tick();
    endtask

    initial begin
        logic exp_lsu;
        logic prev_lsu;

        // Reset: all handshakes held low even with requests pending.
        idle();
        rst           = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        tick();
        settle();
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_ifu_ready", ifu_req_ready, 1'b0);
        check("rst_lsu_ready", lsu_req_ready, 1'b0);
        check("rst_ifu_resp", ifu_resp_valid, 1'b0);
        check("rst_lsu_resp", lsu_resp_valid, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // Both requesting every cycle: L,L,L,I repeating; responses one cycle later.
        prev_lsu = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle();
            ifu_req_valid  = 1'b1;
            ifu_req_addr   = 32'h0000_1000;
            lsu_req_valid  = 1'b1;
            lsu_req_be     = 4'hF;
            lsu_req_addr   = 32'h0000_2000;
            mem_resp_valid = (k > 0);
            settle();
            exp_lsu = (k % 4 != 3);
            check("starve_lsu_grant", lsu_req_ready, exp_lsu);
            check("starve_ifu_grant", ifu_req_ready, !exp_lsu);
            check("starve_req_addr", mem_req_addr, exp_lsu ? 32'h2000 : 32'h1000);
            if (k > 0) begin
                check("starve_resp_lsu", lsu_resp_valid, prev_lsu);
                check("starve_resp_ifu", ifu_resp_valid, !prev_lsu);
            end
            prev_lsu = exp_lsu;
            tick();
        end
        resp(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);

        // LSU load in the upper lane.
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_be    = 4'hF;
        lsu_req_addr  = 32'h0000_0104;
        settle();
        check("ld_ready", lsu_req_ready, 1'b1);
        check("ld_addr", mem_req_addr, 32'h0000_0100);
        check("ld_be", mem_req_be, 8'hF0);
        check("ld_we", mem_req_we, 1'b0);
        tick();
        idle();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        check("ld_resp_valid", lsu_resp_valid, 1'b1);
        check("ld_resp_rdata", lsu_resp_rdata, 32'hAAAA_BBBB);
        check("ld_resp_ifu", ifu_resp_valid, 1'b0);
        tick();

        // LSU store in the lower lane.
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_we    = 1'b1;
        lsu_req_be    = 4'b0011;
        lsu_req_addr  = 32'h0000_0200;
        lsu_req_wdata = 32'h1234_5678;
        settle();
        check("st_addr", mem_req_addr, 32'h0000_0200);
        check("st_be", mem_req_be, 8'h03);
        check("st_wdata", mem_req_wdata, 64'h1234_5678_1234_5678);
        check("st_we", mem_req_we, 1'b1);
        tick();
        resp(64'h0, 1'b0, 1'b1);

        // Four fetches fill the FIFO; the fifth waits for the first response.
        idle();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0305;
        settle();
        check("fill_addr_align", mem_req_addr, 32'h0000_0300);
        check("fill_be", mem_req_be, 8'hFF);
        check("fill_we", mem_req_we, 1'b0);
        check("fill_ready0", ifu_req_ready, 1'b1);
        tick();
        ifu_fetch(32'h0000_0308, 1'b1);
        ifu_fetch(32'h0000_0310, 1'b1);
        ifu_fetch(32'h0000_0318, 1'b1);
        idle();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0320;
        settle();
        check("full_ready", ifu_req_ready, 1'b0);
        check("full_mem_valid", mem_req_valid, 1'b0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hD0D0_D0D0_0000_0300;
        settle();
        check("full_pop_ready", ifu_req_ready, 1'b1);
        check("full_pop_resp", ifu_resp_valid, 1'b1);
        check("full_pop_data", ifu_resp_data, 64'hD0D0_D0D0_0000_0300);
        tick();
        for (int i = 0; i < 4; i++) resp(64'hF000_0000_0000_0000 + 64'(i), 1'b1, 1'b0);

        // Flush kills fetches in flight; the fetch after the flush survives.
        ifu_fetch(32'h0000_0380, 1'b1);
        ifu_fetch(32'h0000_0388, 1'b1);
        ifu_fetch(32'h0000_0390, 1'b1);
        idle();
        ifu_flush = 1'b1;
        tick();
        idle();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0400;
        settle();
        check("post_flush_ready", ifu_req_ready, 1'b1);
        check("post_flush_addr", mem_req_addr, 32'h0000_0400);
        tick();
        for (int i = 0; i < 3; i++) resp(64'hDEAD_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        resp(64'h4444_0000_0000_0400, 1'b1, 1'b0);

        // A fetch issued in the flush cycle is itself killed.
        idle();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h0000_0500;
        ifu_flush     = 1'b1;
        tick();
        resp(64'h5555_0000_0000_0500, 1'b0, 1'b0);

        // Interleaved L, I, L: responses follow issue order and lanes.
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_be    = 4'hF;
        lsu_req_addr  = 32'h0000_0504;
        tick();
        ifu_fetch(32'h0000_0600, 1'b1);
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_be    = 4'hF;
        lsu_req_addr  = 32'h0000_0508;
        tick();
        idle();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h1111_2222_3333_4444;
        settle();
        check("il_r1_lsu", lsu_resp_valid, 1'b1);
        check("il_r1_data", lsu_resp_rdata, 32'h1111_2222);
        tick();
        resp(64'h6666_0000_0000_0600, 1'b1, 1'b0);
        idle();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'h7777_8888_9999_AAAA;
        settle();
        check("il_r3_lsu", lsu_resp_valid, 1'b1);
        check("il_r3_data", lsu_resp_rdata, 32'h9999_AAAA);
        tick();

        // Reset with two requests outstanding discards them.
        idle();
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h0000_0700;
        tick();
        ifu_fetch(32'h0000_0800, 1'b1);
        idle();
        rst           = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        settle();
        check("mid_rst_mem_valid", mem_req_valid, 1'b0);
        check("mid_rst_lsu_ready", lsu_req_ready, 1'b0);
        check("mid_rst_ifu_ready", ifu_req_ready, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("post_rst_ifu_resp", ifu_resp_valid, 1'b0);
        check("post_rst_lsu_resp", lsu_resp_valid, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) ifu_fetch(32'h0000_0900 + 32'(i * 8), 1'b1);
        ifu_fetch(32'h0000_0920, 1'b0);
        for (int i = 0; i < 4; i++) resp(64'h9000_0000_0000_0000 + 64'(i), 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
